// File: rtl/univ_shift_reg_n.sv
// Universal shift register with a burst sequencer.
// Holds a WIDTH-bit word that can hold, load, shift, rotate or arithmetic-shift
// by one position per clock. A start request with a shift-class mode runs that
// operation for `count` consecutive clocks, flagging busy and pulsing done.
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] Q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;

    // One step of the selected operation applied to the current word.
    function automatic logic [WIDTH-1:0] step_word(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] load,
        input logic             s_r,
        input logic             s_l
    );
        case (op)
            MODE_SHR:  step_word = {s_r, cur[WIDTH-1:1]};
            MODE_SHL:  step_word = {cur[WIDTH-2:0], s_l};
            MODE_LOAD: step_word = load;
            MODE_ROR:  step_word = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  step_word = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_ASR:  step_word = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default:   step_word = cur;
        endcase
    endfunction

    // Only operations that move bits are worth repeating in a burst.
    function automatic logic is_shift_class(input logic [2:0] op);
        is_shift_class = (op == MODE_SHR) || (op == MODE_SHL) ||
                         (op == MODE_ROR) || (op == MODE_ROL) ||
                         (op == MODE_ASR);
    endfunction

    // Next-state logic: single steps in IDLE, latched operation stepping in BURST.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        op_d    = op_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && is_shift_class(mode)) begin
                    op_d  = mode;
                    rem_d = count;
                    if (count != '0) begin
                        state_d = BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    q_d = step_word(mode, q_q, D, sin_r, sin_l);
                end
            end
            BURST: begin
                q_d   = step_word(op_q, q_q, D, sin_r, sin_l);
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; clr low clears everything at once, aborting any burst.
    always_ff @(posedge Clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            q_q     <= '0;
            op_q    <= MODE_HOLD;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Outputs are direct views of the stored state.
    always_comb begin
        Q    = q_q;
        so_r = q_q[0];
        so_l = q_q[WIDTH-1];
        busy = (state_q == BURST);
        done = done_q;
    end

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Testbench for univ_shift_reg_n: directed scenarios plus random traffic,
// checked per cycle by a scoreboard fed from an arithmetic reference model.
module tb_univ_shift_reg_n;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             Clk = 1'b0;
    logic             clr;
    logic [2:0]       mode;
    logic [WIDTH-1:0] D;
    logic             sin_r;
    logic             sin_l;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] Q;
    logic             so_r;
    logic             so_l;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: word value, pending burst steps and latched operation.
    int m_val;
    int m_pending;
    int m_op;
    bit m_done;

    univ_shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .clr   (clr),
        .mode  (mode),
        .D     (D),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .start (start),
        .count (count),
        .Q     (Q),
        .so_r  (so_r),
        .so_l  (so_l),
        .busy  (busy),
        .done  (done)
    );

    // Free-running clock, period 10.
    always #5 Clk = ~Clk;

    function automatic int model_step(int op, int val, int load, int sr, int sl);
        case (op)
            1:       return (val >> 1) | (sr << (WIDTH - 1));
            2:       return ((val << 1) | sl) & MASK;
            3:       return load & MASK;
            4:       return (val >> 1) | ((val & 1) << (WIDTH - 1));
            5:       return ((val << 1) & MASK) | (val >> (WIDTH - 1));
            6:       return (val >> 1) | (val & (1 << (WIDTH - 1)));
            default: return val;
        endcase
    endfunction

    function automatic bit model_is_shift(int op);
        return (op == 1) || (op == 2) || (op == 4) || (op == 5) || (op == 6);
    endfunction

    task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_output(input exp_t e);
        check_val("Q",    32'(Q),    32'(e.q));
        check_val("busy", 32'(busy), 32'(e.busy));
        check_val("done", 32'(done), 32'(e.done));
        check_val("so_r", 32'(so_r), 32'(e.q[0]));
        check_val("so_l", 32'(so_l), 32'(e.q[WIDTH-1]));
    endtask

    // Monitor: each falling edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    // Drive one clock's inputs, advance the model, and queue the post-edge result.
    task automatic apply_stimulus(input logic [2:0] m, input logic [WIDTH-1:0] d,
                                  input logic sr, input logic sl,
                                  input logic st, input logic [CNT_W-1:0] c);
        exp_t e;
        mode  = m;
        D     = d;
        sin_r = sr;
        sin_l = sl;
        start = st;
        count = c;
        if (m_pending > 0) begin
            m_val     = model_step(m_op, m_val, 0, int'(sr), int'(sl));
            m_pending = m_pending - 1;
            m_done    = (m_pending == 0);
        end else if (st && model_is_shift(int'(m))) begin
            m_op      = int'(m);
            m_pending = int'(c);
            m_done    = (c == 0);
        end else begin
            m_val  = model_step(int'(m), m_val, int'(d), int'(sr), int'(sl));
            m_done = 1'b0;
        end
        @(posedge Clk);
        #1;
        e.q    = m_val[WIDTH-1:0];
        e.busy = (m_pending > 0);
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic hold_cycle();
        apply_stimulus(3'b000, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic model_reset();
        m_val     = 0;
        m_pending = 0;
        m_op      = 0;
        m_done    = 1'b0;
    endtask

    // Pulse clr low mid-cycle, check the immediate clear, then release after a falling edge.
    task automatic async_reset(input string name);
        exp_t e;
        #2;
        clr = 1'b0;
        #1;
        check_val({name, "_Q"},    32'(Q),    32'h0);
        check_val({name, "_busy"}, 32'(busy), 32'h0);
        check_val({name, "_done"}, 32'(done), 32'h0);
        exp_q.delete();
        model_reset();
        e.q    = '0;
        e.busy = 1'b0;
        e.done = 1'b0;
        exp_q.push_back(e);
        mode  = 3'b000;
        start = 1'b0;
        @(negedge Clk);
        #1;
        clr = 1'b1;
    endtask

    typedef struct {
        logic [2:0]       m;
        logic             sr;
        logic             sl;
        logic [WIDTH-1:0] want;
    } single_t;

    initial begin
        single_t    singles[7];
        logic [7:0] stream;

        singles[0] = '{3'b001, 1'b1, 1'b0, 8'hCB};
        singles[1] = '{3'b010, 1'b0, 1'b0, 8'h2C};
        singles[2] = '{3'b100, 1'b0, 1'b0, 8'h4B};
        singles[3] = '{3'b101, 1'b0, 1'b0, 8'h2D};
        singles[4] = '{3'b110, 1'b0, 1'b0, 8'hCB};
        singles[5] = '{3'b111, 1'b0, 1'b0, 8'h96};
        singles[6] = '{3'b000, 1'b1, 1'b1, 8'h96};
        stream     = 8'b0100_1101;

        clr   = 1'b0;
        mode  = 3'b000;
        D     = '0;
        sin_r = 1'b0;
        sin_l = 1'b0;
        start = 1'b0;
        count = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_val("reset_Q",    32'(Q),    32'h0);
        check_val("reset_busy", 32'(busy), 32'h0);
        check_val("reset_done", 32'(done), 32'h0);
        clr = 1'b1;

        // Asynchronous clear with a non-zero word.
        apply_stimulus(3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, '0);
        check_val("load_A5", 32'(Q), 32'hA5);
        async_reset("async_clr");

        // Single steps from 0x96.
        foreach (singles[i]) begin
            apply_stimulus(3'b011, 8'h96, 1'b0, 1'b0, 1'b0, '0);
            apply_stimulus(singles[i].m, 8'h00, singles[i].sr, singles[i].sl, 1'b0, '0);
            check_val($sformatf("single_mode%0d", singles[i].m), 32'(Q), 32'(singles[i].want));
        end

        // Load then rotate-left burst of 3 with mode toggled underneath.
        apply_stimulus(3'b011, 8'h81, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
        check_val("burst_busy_e0", 32'(busy), 32'h1);
        apply_stimulus(3'b011, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd7);
        apply_stimulus(3'b001, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd1);
        apply_stimulus(3'b010, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd2);
        check_val("burst_rol3_Q",    32'(Q),    32'h0C);
        check_val("burst_rol3_done", 32'(done), 32'h1);
        check_val("burst_rol3_busy", 32'(busy), 32'h0);
        hold_cycle();
        check_val("burst_done_clears", 32'(done), 32'h0);

        // Zero-count burst: done next cycle, nothing moves.
        apply_stimulus(3'b001, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0);
        check_val("cnt0_done", 32'(done), 32'h1);
        check_val("cnt0_Q",    32'(Q),    32'h0C);
        hold_cycle();

        // Rotate right 9 times across an 8-bit word wraps around.
        apply_stimulus(3'b011, 8'h01, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 4'd9);
        repeat (9) hold_cycle();
        check_val("ror9_Q",    32'(Q),    32'h80);
        check_val("ror9_done", 32'(done), 32'h1);

        // Serial stream into the MSB over an 8-step right-shift burst.
        apply_stimulus(3'b011, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(3'b001, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(3'b000, 8'h00, stream[i], 1'b0, 1'b0, '0);
        end
        check_val("serial_Q",    32'(Q),    32'h4D);
        check_val("serial_done", 32'(done), 32'h1);

        // Abort a 5-step burst after two steps.
        apply_stimulus(3'b011, 8'h3C, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(3'b010, 8'h00, 1'b0, 1'b1, 1'b1, 4'd5);
        apply_stimulus(3'b000, 8'h00, 1'b0, 1'b1, 1'b0, '0);
        apply_stimulus(3'b000, 8'h00, 1'b0, 1'b1, 1'b0, '0);
        async_reset("abort");
        repeat (5) hold_cycle();

        // Re-arm in the done cycle with no gap.
        apply_stimulus(3'b011, 8'hC3, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2);
        hold_cycle();
        hold_cycle();
        check_val("rearm_first_done", 32'(done), 32'h1);
        apply_stimulus(3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
        check_val("rearm_busy", 32'(busy), 32'h1);
        repeat (3) hold_cycle();
        check_val("rearm_second_done", 32'(done), 32'h1);

        // Random traffic, with occasional asynchronous clears.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rand_clr");
            end
            apply_stimulus(3'($urandom_range(0, 7)), 8'($urandom()),
                           1'($urandom()), 1'($urandom()),
                           ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
        end

        @(negedge Clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
